// File: rtl/pipe_buffer_chain.sv
// pipe_buffer_chain
//   Parametrised pipeline register chain between decode and write-back.
//   Each stage carries a valid bit, an opaque payload and a register-write
//   record (wr_en, wr_addr, wr_data). The hazard unit drives per-stage stall
//   and flush requests. A combinational lookup forwards the youngest
//   in-flight register write to each source port.
//
// Optional feature macro: PIPE_STATS_EN
//   When defined, adds the 32-bit wrapping counters stall_cycles and
//   bubble_cycles.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid/in_ready       stage-0 handshake (in_ready = ~hold[0])
//   in_data, in_wr_*        entry presented to stage 0
//   stall_i, flush_i        per-stage hold / kill requests
//   stage_valid             valid bit of every stage
//   out_valid, out_data,
//   out_wr_en/addr/data     contents of the oldest stage (wr_en gated by valid)
//   src_addr                NUM_SRC packed lookup addresses
//   fwd_hit, fwd_data       per-port forwarding result (data 0 on miss)
//   stall_cycles,
//   bubble_cycles           statistics counters (PIPE_STATS_EN only)
module pipe_buffer_chain #(
  parameter int DATA_WIDTH = 64,
  parameter int RES_WIDTH  = 16,
  parameter int ADDR_WIDTH = 3,
  parameter int STAGES     = 3,
  parameter int NUM_SRC    = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DATA_WIDTH-1:0]           in_data,
  input  logic                            in_wr_en,
  input  logic [ADDR_WIDTH-1:0]           in_wr_addr,
  input  logic [RES_WIDTH-1:0]            in_wr_data,
  input  logic [STAGES-1:0]               stall_i,
  input  logic [STAGES-1:0]               flush_i,
  output logic [STAGES-1:0]               stage_valid,
  output logic                            out_valid,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic                            out_wr_en,
  output logic [ADDR_WIDTH-1:0]           out_wr_addr,
  output logic [RES_WIDTH-1:0]            out_wr_data,
  input  logic [NUM_SRC*ADDR_WIDTH-1:0]   src_addr,
  output logic [NUM_SRC-1:0]              fwd_hit,
  output logic [NUM_SRC*RES_WIDTH-1:0]    fwd_data
`ifdef PIPE_STATS_EN
  ,
  output logic [31:0]                     stall_cycles,
  output logic [31:0]                     bubble_cycles
`endif
);

  logic [STAGES-1:0]                 r_valid;
  logic [STAGES-1:0][DATA_WIDTH-1:0] r_data;
  logic [STAGES-1:0]                 r_wr_en;
  logic [STAGES-1:0][ADDR_WIDTH-1:0] r_wr_addr;
  logic [STAGES-1:0][RES_WIDTH-1:0]  r_wr_data;

  // w_hold[k]: some stage at or after k is stalled, so k cannot advance.
  // w_kill[k]: some stage at or after k is flushed, so k is discarded.
  logic [STAGES-1:0] w_hold;
  logic [STAGES-1:0] w_kill;

  assign w_hold[STAGES-1] = stall_i[STAGES-1];
  assign w_kill[STAGES-1] = flush_i[STAGES-1];

  genvar gi;
  generate
    for (gi = 0; gi < STAGES - 1; gi++) begin : g_suffix_or
      assign w_hold[gi] = stall_i[gi] | w_hold[gi+1];
      assign w_kill[gi] = flush_i[gi] | w_kill[gi+1];
    end
  endgenerate

  assign in_ready = ~w_hold[0];

  // Stage registers. Payload fields hold on flush; they are ignored while
  // the stage is invalid.
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_valid[gi]   <= 1'b0;
          r_data[gi]    <= '0;
          r_wr_en[gi]   <= 1'b0;
          r_wr_addr[gi] <= '0;
          r_wr_data[gi] <= '0;
        end else if (w_kill[gi]) begin
          r_valid[gi] <= 1'b0;
        end else if (w_hold[gi]) begin
          r_valid[gi] <= r_valid[gi];
        end else if (gi == 0) begin
          r_valid[gi]   <= in_valid & in_ready;
          r_data[gi]    <= in_data;
          r_wr_en[gi]   <= in_wr_en;
          r_wr_addr[gi] <= in_wr_addr;
          r_wr_data[gi] <= in_wr_data;
        end else if (w_hold[(gi == 0) ? 0 : gi-1]) begin
          // Upstream is frozen while this stage drains: insert a bubble.
          r_valid[gi] <= 1'b0;
        end else begin
          r_valid[gi]   <= r_valid[(gi == 0) ? 0 : gi-1];
          r_data[gi]    <= r_data[(gi == 0) ? 0 : gi-1];
          r_wr_en[gi]   <= r_wr_en[(gi == 0) ? 0 : gi-1];
          r_wr_addr[gi] <= r_wr_addr[(gi == 0) ? 0 : gi-1];
          r_wr_data[gi] <= r_wr_data[(gi == 0) ? 0 : gi-1];
        end
      end
    end
  endgenerate

  assign stage_valid = r_valid;
  assign out_valid   = r_valid[STAGES-1];
  assign out_data    = r_data[STAGES-1];
  assign out_wr_en   = r_valid[STAGES-1] & r_wr_en[STAGES-1];
  assign out_wr_addr = r_wr_addr[STAGES-1];
  assign out_wr_data = r_wr_data[STAGES-1];

  // Forwarding: scan oldest to youngest so a younger match overwrites an
  // older one, leaving the youngest writer as the result.
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_fwd
      logic                 w_hit;
      logic [RES_WIDTH-1:0] w_data;
      always_comb begin
        w_hit  = 1'b0;
        w_data = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
          if (r_valid[k] && r_wr_en[k] &&
              (r_wr_addr[k] == src_addr[gi*ADDR_WIDTH +: ADDR_WIDTH])) begin
            w_hit  = 1'b1;
            w_data = r_wr_data[k];
          end
        end
      end
      assign fwd_hit[gi] = w_hit;
      assign fwd_data[gi*RES_WIDTH +: RES_WIDTH] = w_data;
    end
  endgenerate

`ifdef PIPE_STATS_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_bubble_cycles;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles  <= '0;
      r_bubble_cycles <= '0;
    end else begin
      if (w_hold[0])
        r_stall_cycles <= r_stall_cycles + 32'd1;
      if (!r_valid[STAGES-1])
        r_bubble_cycles <= r_bubble_cycles + 32'd1;
    end
  end

  assign stall_cycles  = r_stall_cycles;
  assign bubble_cycles = r_bubble_cycles;
`endif

endmodule

// File: doc/pipe_buffer_chain.md
Name: pipe_buffer_chain

Overview:
Parametrised multi-stage pipeline register chain for the five-stage processor. It replaces the fixed per-stage buffers with a single block that provides:
- a valid bit per stage
- per-stage stall (hold) and flush (bubble insertion)
- combinational register-write forwarding lookup across all in-flight stages

It sits between decode and write-back; the hazard unit drives its stall and flush inputs.

Parameters:
DATA_WIDTH, 64, width of the opaque payload (control signals, immediates, operands) carried per stage
RES_WIDTH, 16, width of the register-write result carried per stage
ADDR_WIDTH, 3, register-file address width
STAGES, 3, number of pipeline register stages (>=1); stage 0 is youngest
NUM_SRC, 2, number of forwarding lookup ports

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  new entry presented to stage 0
in_ready  out  1  stage 0 can accept (= ~hold[0])
in_data  in  DATA_WIDTH  payload
in_wr_en  in  1  entry writes the register file
in_wr_addr  in  ADDR_WIDTH  destination register
in_wr_data  in  RES_WIDTH  result value
stall_i  in  STAGES  per-stage hold request
flush_i  in  STAGES  per-stage kill request
stage_valid  out  STAGES  valid bit of each stage
out_valid  out  1  valid of stage STAGES-1
out_data  out  DATA_WIDTH  payload of last stage
out_wr_en  out  1  wr_en of last stage, gated by out_valid
out_wr_addr  out  ADDR_WIDTH  destination of last stage
out_wr_data  out  RES_WIDTH  result of last stage
src_addr  in  NUM_SRC*ADDR_WIDTH  lookup addresses, port j at bits [j*ADDR_WIDTH +: ADDR_WIDTH]
fwd_hit  out  NUM_SRC  lookup j matched an in-flight write
fwd_data  out  NUM_SRC*RES_WIDTH  forwarded value for port j

Behaviour:
- Reset (async, rst_n=0):
  - all stage valid bits cleared, so stage_valid=0, out_valid=0, out_wr_en=0, fwd_hit=0
  - data, addr and result fields cleared to 0
- Hold vector: hold[k] = OR of stall_i[k..STAGES-1]. A stalled stage also holds every younger stage.
- Per-stage update each rising edge, highest priority first:
  1. flush: if any flush_i[m] with m>=k is set, valid[k] <= 0. Flush kills the stage and all younger stages, and overrides stall. Data fields may update or hold; they are don't-care when invalid.
  2. hold[k]=1: stage k keeps all fields.
  3. k>0 and hold[k-1]=1 (upstream held, this stage free): valid[k] <= 0 (bubble inserted).
  4. otherwise the stage loads from its predecessor. Stage 0 loads from the inputs with valid[0] <= in_valid & in_ready.
- Latency: an entry accepted at edge n appears on out_* after STAGES edges with no stall or flush.
- in_ready is combinational and equals ~hold[0]. Entries offered while in_ready=0 are not captured; the source must hold them.
- Forwarding, per port j (combinational, zero latency):
  - search stage 0 then 1 ... STAGES-1; the first stage with valid & wr_en & wr_addr==src_addr[j] wins
  - fwd_hit[j]=1 and fwd_data[j]=that stage's wr_data
  - no match: fwd_hit[j]=0 and fwd_data[j]=0
  - the youngest match always wins over older matches
- A stalled stage still participates in forwarding.
- Simultaneous stall_i and flush_i on the same stage: flush wins.
- Asserting rst_n mid-operation discards all in-flight entries immediately, without waiting for a clock edge.

Optional Feature:
PIPE_STATS_EN
- Defined: adds outputs stall_cycles (32-bit) and bubble_cycles (32-bit). Both reset to 0 and wrap at 2^32-1 -> 0.
  - stall_cycles increments each edge that hold[0]=1.
  - bubble_cycles increments each edge on which out_valid=0 while rst_n=1.
- Undefined: neither port nor counter logic exists; all other behaviour is identical.

Test Plan:
- Reset then stream 4 entries (wr_addr 1..4, wr_data 0x0011..0x0044), STAGES=3 -> out_valid first rises 3 edges after the first accept; outputs in order; stage_valid=3'b111 while streaming.
- Entry wr_addr=5/0x00AA in stage 2 and wr_addr=5/0x00BB in stage 0, src_addr[0]=5 -> fwd_hit[0]=1, fwd_data[0]=0x00BB; src_addr[1]=6 -> fwd_hit[1]=0, fwd_data[1]=0.
- stall_i=3'b010 for 2 cycles with full pipe -> stages 0-1 hold, stage 2 gets a bubble (out_valid=0 one cycle later), in_ready=0 for both cycles, no entry lost or duplicated.
- flush_i=3'b010 together with stall_i=3'b010 -> next edge stage_valid[1:0]=0, stage 2 advances normally.
- Stage with wr_en=0 and wr_addr matching src_addr -> fwd_hit=0.
- rst_n pulled low between edges with 3 valid entries -> stage_valid=0 and out_wr_en=0 immediately; with PIPE_STATS_EN defined, both counters read 0.
